// File: rtl/aukv_lsu_if.sv
// Data-bus bundle between the aukv_lsu memory stage and the data memory/bus fabric.
// Member names match the legacy flat port names so existing bus wiring maps one-to-one.
interface aukv_lsu_if;
  logic        o_dbus_req;
  logic        o_dbus_we;
  logic [31:0] o_dbus_addr;
  logic [31:0] o_dbus_wdata;
  logic [3:0]  o_dbus_be;
  logic        i_dbus_ack;
  logic [31:0] i_dbus_rdata;

  modport master (
    output o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_be,
    input  i_dbus_ack, i_dbus_rdata
  );

  modport slave (
    input  o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_be,
    output i_dbus_ack, i_dbus_rdata
  );
endinterface

// File: rtl/aukv_lsu.sv
// RV32I memory stage: passes ALU results through, runs the req/ack data-bus access for
// loads/stores with byte-lane alignment, and reports misalignment and bus-timeout exceptions.
module aukv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [4:0]  i_rd_idx,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_rd_data,
  output logic [4:0]  o_rd_idx,
  output logic        o_rd_we,
  output logic        o_exc,
  output logic [1:0]  o_exc_code,
  aukv_lsu_if.master  dbus
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic          req_q, we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [1:0]    lo_q, size_q;
  logic          uns_q;
  logic [4:0]    rd_q;

  logic        accept, is_mem, misal, go_wait, ack_hit, tmo_hit;
  logic [31:0] ld_data, lane;

  assign dbus.o_dbus_req   = req_q;
  assign dbus.o_dbus_we    = we_q;
  assign dbus.o_dbus_addr  = addr_q;
  assign dbus.o_dbus_wdata = wdata_q;
  assign dbus.o_dbus_be    = be_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_wait) state_d = WAIT;
      WAIT:    if (ack_hit || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_stall = (state_q == WAIT);
    accept  = (state_q == IDLE) && i_valid;
    is_mem  = i_load || i_store;
    // Size 3 decodes as word, so size[1] alone selects the word alignment rule.
    misal   = ((i_size == 2'd1) && i_alu_result[0]) ||
              (i_size[1] && (i_alu_result[1:0] != 2'b00));
    go_wait = accept && is_mem && !misal;
    ack_hit = (state_q == WAIT) && dbus.i_dbus_ack;
    tmo_hit = (state_q == WAIT) && !dbus.i_dbus_ack && (TIMEOUT != 0) &&
              (cnt_q == CW'(TIMEOUT - 1));
  end

  always_comb begin
    lane = dbus.i_dbus_rdata >> {lo_q, 3'b000};
    case (size_q)
      2'd0:    ld_data = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'd1:    ld_data = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lo_q       <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      o_valid    <= 1'b0;
      o_rd_data  <= '0;
      o_rd_idx   <= '0;
      o_rd_we    <= 1'b0;
      o_exc      <= 1'b0;
      o_exc_code <= '0;
    end else begin
      o_valid <= 1'b0;
      o_rd_we <= 1'b0;
      o_exc   <= 1'b0;

      if (accept && !go_wait) begin
        o_valid    <= 1'b1;
        o_rd_idx   <= i_rd_idx;
        if (is_mem) begin
          o_exc      <= 1'b1;
          o_exc_code <= i_load ? 2'd1 : 2'd2;
        end else begin
          o_rd_data  <= i_alu_result;
          o_rd_we    <= (i_rd_idx != 5'd0);
          o_exc_code <= 2'd0;
        end
      end

      if (go_wait) begin
        cnt_q   <= '0;
        req_q   <= 1'b1;
        we_q    <= i_store;
        addr_q  <= {i_alu_result[31:2], 2'b00};
        lo_q    <= i_alu_result[1:0];
        size_q  <= i_size;
        uns_q   <= i_unsigned;
        rd_q    <= i_rd_idx;
        case (i_size)
          2'd0: begin
            be_q    <= 4'b0001 << i_alu_result[1:0];
            wdata_q <= {4{i_store_data[7:0]}};
          end
          2'd1: begin
            be_q    <= 4'b0011 << i_alu_result[1:0];
            wdata_q <= {2{i_store_data[15:0]}};
          end
          default: begin
            be_q    <= 4'b1111;
            wdata_q <= i_store_data;
          end
        endcase
      end else if (state_q == WAIT) begin
        if (ack_hit) begin
          req_q      <= 1'b0;
          o_valid    <= 1'b1;
          o_rd_idx   <= rd_q;
          o_exc_code <= 2'd0;
          if (!we_q) begin
            o_rd_data <= ld_data;
            o_rd_we   <= (rd_q != 5'd0);
          end
        end else if (tmo_hit) begin
          req_q      <= 1'b0;
          o_valid    <= 1'b1;
          o_rd_idx   <= rd_q;
          o_exc      <= 1'b1;
          o_exc_code <= 2'd3;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aukv_lsu.sv
// Directed bench for aukv_lsu: expected writeback results are queued at issue time and
// compared against every o_valid pulse; bus fields and stall are checked inline.
module tb_aukv_lsu;
  localparam int unsigned TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_store_data = '0;
  logic        i_load = 1'b0;
  logic        i_store = 1'b0;
  logic [1:0]  i_size = '0;
  logic        i_unsigned = 1'b0;
  logic [4:0]  i_rd_idx = '0;
  logic        o_stall, o_valid, o_rd_we, o_exc;
  logic [31:0] o_rd_data;
  logic [4:0]  o_rd_idx;
  logic [1:0]  o_exc_code;

  aukv_lsu_if dbus ();

  aukv_lsu #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_alu_result(i_alu_result),
    .i_store_data(i_store_data), .i_load(i_load), .i_store(i_store), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_rd_idx(i_rd_idx), .o_stall(o_stall), .o_valid(o_valid),
    .o_rd_data(o_rd_data), .o_rd_idx(o_rd_idx), .o_rd_we(o_rd_we), .o_exc(o_exc),
    .o_exc_code(o_exc_code), .dbus(dbus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        we;
    logic        exc;
    logic [1:0]  code;
    logic        chk_data;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", {31'b0, o_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("wb_idx", {27'b0, o_rd_idx}, {27'b0, e.idx});
        chk("wb_we", {31'b0, o_rd_we}, {31'b0, e.we});
        chk("wb_exc", {31'b0, o_exc}, {31'b0, e.exc});
        if (e.exc) chk("wb_code", {30'b0, o_exc_code}, {30'b0, e.code});
        if (e.chk_data) chk("wb_data", o_rd_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] idx, input logic we,
                      input logic exc, input logic [1:0] code, input logic cd);
    exp_t e;
    e.data = d; e.idx = idx; e.we = we; e.exc = exc; e.code = code; e.chk_data = cd;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
    i_valid = 1'b1; i_load = ld; i_store = st; i_size = sz; i_unsigned = uns;
    i_alu_result = addr; i_store_data = data; i_rd_idx = rd;
    tick();
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
  endtask

  // Called one cycle into WAIT; acks after 'delay' further cycles.
  task automatic bus_wait(input int delay, input logic [31:0] rdata, input string tag);
    for (int i = 0; i <= delay; i++) begin
      chk({tag, "_stall"}, {31'b0, o_stall}, 32'd1);
      chk({tag, "_req"}, {31'b0, dbus.o_dbus_req}, 32'd1);
      if (i == delay) begin
        dbus.i_dbus_ack = 1'b1;
        dbus.i_dbus_rdata = rdata;
      end
      tick();
      dbus.i_dbus_ack = 1'b0;
    end
    chk({tag, "_done_stall"}, {31'b0, o_stall}, 32'd0);
    chk({tag, "_done_req"}, {31'b0, dbus.o_dbus_req}, 32'd0);
  endtask

  initial begin
    dbus.i_dbus_ack = 1'b0;
    dbus.i_dbus_rdata = '0;
    #3;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    chk("rst_req", {31'b0, dbus.o_dbus_req}, 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);
    chk("rst_be", {28'b0, dbus.o_dbus_be}, 32'd0);
    tick();
    i_rstn = 1'b1;
    tick();

    // ALU pass-through
    push(32'h1234, 5'd5, 1'b1, 1'b0, 2'd0, 1'b1);
    drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 5'd5);
    chk("t1_stall", {31'b0, o_stall}, 32'd0);
    chk("t1_req", {31'b0, dbus.o_dbus_req}, 32'd0);
    push(32'hDEAD0000, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    drive(1'b0, 1'b0, 2'd2, 1'b0, 32'hDEAD0000, 32'h0, 5'd0);

    // LB / LBU at byte 3
    push(32'hFFFFFF80, 5'd7, 1'b1, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7);
    chk("lb_addr", dbus.o_dbus_addr, 32'h100);
    chk("lb_be", {28'b0, dbus.o_dbus_be}, 32'h8);
    chk("lb_we", {31'b0, dbus.o_dbus_we}, 32'd0);
    bus_wait(3, 32'h80FFFFFF, "lb");
    push(32'h00000080, 5'd8, 1'b1, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd8);
    bus_wait(1, 32'h80FFFFFF, "lbu");

    // SH upper half, immediate ack
    push(32'h0, 5'd9, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'hABCD1234, 5'd9);
    chk("sh_addr", dbus.o_dbus_addr, 32'h200);
    chk("sh_be", {28'b0, dbus.o_dbus_be}, 32'hC);
    chk("sh_wdata", dbus.o_dbus_wdata, 32'h12341234);
    chk("sh_we", {31'b0, dbus.o_dbus_we}, 32'd1);
    bus_wait(0, 32'h0, "sh");

    // SB, SW, LH, LHU, load to x0
    push(32'h0, 5'd3, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h401, 32'h00000155, 5'd3);
    chk("sb_be", {28'b0, dbus.o_dbus_be}, 32'h2);
    chk("sb_wdata", dbus.o_dbus_wdata, 32'h55555555);
    bus_wait(0, 32'h0, "sb");
    push(32'h0, 5'd4, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 1'b0, 32'h500, 32'hDEADBEEF, 5'd4);
    chk("sw_be", {28'b0, dbus.o_dbus_be}, 32'hF);
    chk("sw_wdata", dbus.o_dbus_wdata, 32'hDEADBEEF);
    bus_wait(2, 32'h0, "sw");
    push(32'hFFFF8001, 5'd6, 1'b1, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h302, 32'h0, 5'd6);
    chk("lh_be", {28'b0, dbus.o_dbus_be}, 32'hC);
    bus_wait(0, 32'h80010000, "lh");
    push(32'h0000ABCD, 5'd6, 1'b1, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h300, 32'h0, 5'd6);
    bus_wait(0, 32'h1234ABCD, "lhu");
    push(32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h310, 32'h0, 5'd0);
    bus_wait(0, 32'h11111111, "lw_x0");

    // Misaligned accesses never touch the bus
    push(32'h0, 5'd10, 1'b0, 1'b1, 2'd1, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd10);
    chk("mis_ld_req", {31'b0, dbus.o_dbus_req}, 32'd0);
    chk("mis_ld_stall", {31'b0, o_stall}, 32'd0);
    push(32'h0, 5'd11, 1'b0, 1'b1, 2'd2, 1'b0);
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h101, 32'h0, 5'd11);
    chk("mis_st_req", {31'b0, dbus.o_dbus_req}, 32'd0);
    tick();

    // Ack while idle must be ignored
    dbus.i_dbus_ack = 1'b1;
    tick();
    dbus.i_dbus_ack = 1'b0;
    tick();

    // Timeout after exactly TO request cycles, then ack on the last cycle wins
    push(32'h0, 5'd12, 1'b0, 1'b1, 2'd3, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 5'd12);
    for (int i = 0; i < TO; i++) begin
      chk("tmo_req_high", {31'b0, dbus.o_dbus_req}, 32'd1);
      tick();
    end
    chk("tmo_req_low", {31'b0, dbus.o_dbus_req}, 32'd0);
    chk("tmo_stall_low", {31'b0, o_stall}, 32'd0);
    push(32'hCAFEF00D, 5'd13, 1'b1, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h604, 32'h0, 5'd13);
    bus_wait(TO - 1, 32'hCAFEF00D, "tmo_edge_ack");

    // Reset mid-WAIT: bus released at once, late ack produces nothing
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h700, 32'h0, 5'd14);
    tick();
    i_rstn = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, dbus.o_dbus_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, o_stall}, 32'd0);
    tick();
    i_rstn = 1'b1;
    tick();
    dbus.i_dbus_ack = 1'b1;
    dbus.i_dbus_rdata = 32'h99999999;
    tick();
    dbus.i_dbus_ack = 1'b0;
    push(32'h76543210, 5'd15, 1'b1, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h704, 32'h0, 5'd15);
    chk("post_rst_addr", dbus.o_dbus_addr, 32'h704);
    bus_wait(1, 32'h76543210, "post_rst");

    tick();
    tick();
    chk("sb_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
